// File: rtl/translator_std_pkg.sv
// Shared definitions for the flit/packet translators.
// Flit field positions, FSM encoding and slot helper.
package translator_std_pkg;

  // Field positions, counted down from the flit MSB.
  localparam int FLIT_VALID_OFS = 0;
  localparam int FLIT_HEAD_OFS  = 1;
  localparam int FLIT_TAIL_OFS  = 2;
  localparam int FLIT_VC_OFS    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD
  } asm_state_e;

  // Slot k of a packet word; slot 0 sits at the MSB.
  function automatic logic [63:0] get_slot(
    input logic [255:0] pkt,
    input int unsigned  wpkt,
    input int unsigned  wflit,
    input int unsigned  k
  );
    logic [255:0] s;
    s = pkt >> (wpkt - (k + 1) * wflit);
    return s[63:0] & ((64'd1 << wflit) - 64'd1);
  endfunction

endpackage

// File: rtl/flit_assembler_std.sv
// Flit-serial to packet-word assembler.
// Assembly register plus one buffered output word.
module flit_assembler_std
  import translator_std_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int NUM_FLITS        = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH_PKT/NUM_FLITS-1:0]  flit_in,
  output logic                            ready_out,
  output logic [WIDTH_PKT-1:0]            data_out,
  input  logic                            ready_in,
  output logic                            error_out
);

  localparam int WIDTH_FLIT = WIDTH_PKT / NUM_FLITS;
  localparam int CNT_W      = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int PAYLOAD_W  = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS - 1);

  if (WIDTH_PKT % NUM_FLITS != 0) begin : g_chk_div
    $error("WIDTH_PKT not divisible by NUM_FLITS");
  end
  if (ADDRESS_WIDTH > PAYLOAD_W) begin : g_chk_addr
    $error("flit payload too narrow for ADDRESS_WIDTH");
  end

  asm_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_PKT-1:0] asm_q, asm_d;
  logic [WIDTH_PKT-1:0] out_q, out_d;
  logic                 full_q, full_d;
  logic                 err_q, err_d;

  logic                 f_valid, f_head, f_tail;
  logic                 accept, start, done;
  logic [WIDTH_PKT-1:0] word;

  assign f_valid = flit_in[WIDTH_FLIT-1-FLIT_VALID_OFS];
  assign f_head  = flit_in[WIDTH_FLIT-1-FLIT_HEAD_OFS];
  assign f_tail  = flit_in[WIDTH_FLIT-1-FLIT_TAIL_OFS];

  assign ready_out = (state_q != ST_HOLD);
  assign accept    = f_valid && ready_out;
  assign data_out  = full_q ? out_q : '0;
  assign error_out = err_q;

  // Next-state: slot fill, completion and output-buffer handoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    out_d   = out_q;
    full_d  = full_q;
    err_d   = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    word    = asm_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (f_head) start = 1'b1;
          else        err_d = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          if (f_head) begin
            start = 1'b1;
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < NUM_FLITS; k++) begin
              if (k == int'(cnt_q))
                word[WIDTH_PKT-1-k*WIDTH_FLIT -: WIDTH_FLIT] = flit_in;
            end
            if (f_tail) begin
              done = 1'b1;
            end else if (cnt_q == LAST) begin
              done  = 1'b1;
              err_d = 1'b1;
            end else begin
              asm_d = word;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (ready_in) begin
          out_d   = asm_q;
          full_d  = 1'b1;
          asm_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A head always begins a fresh word in slot 0.
    if (start) begin
      word = '0;
      word[WIDTH_PKT-1 -: WIDTH_FLIT] = flit_in;
      if (f_tail) begin
        done = 1'b1;
      end else begin
        asm_d   = word;
        cnt_d   = CNT_W'(1);
        state_d = ST_COLLECT;
      end
    end

    if (done) begin
      cnt_d = '0;
      if (!full_q || ready_in) begin
        out_d   = word;
        full_d  = 1'b1;
        asm_d   = '0;
        state_d = ST_IDLE;
      end else begin
        asm_d   = word;
        state_d = ST_HOLD;
      end
    end else if (state_q != ST_HOLD && ready_in && full_q) begin
      full_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_flit_assembler_std.sv
// Testbench for flit_assembler_std.
// Directed steps then random traffic against a queue model.
module tb_flit_assembler_std;
  import translator_std_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [8:0]  flit_in;
  logic        ready_out;
  logic [35:0] data_out;
  logic        ready_in;
  logic        error_out;

  int errors = 0;
  int checks = 0;

  flit_assembler_std #(
    .WIDTH_PKT(36),
    .NUM_FLITS(4),
    .VC_ADDRESS_WIDTH(1),
    .ADDRESS_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flit_in(flit_in),
    .ready_out(ready_out),
    .data_out(data_out),
    .ready_in(ready_in),
    .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: packets in progress and a 2-deep word queue.
  logic [8:0]  part[$];
  logic [35:0] fifo[$];
  logic [35:0] exp_data;
  logic        exp_ready;
  logic        exp_err;

  function automatic logic [8:0] mk(input logic h, input logic t,
                                    input logic vc, input logic [4:0] pl);
    return {1'b1, h, t, vc, pl};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs,
                     input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    part.delete();
    fifo.delete();
    exp_data  = '0;
    exp_ready = 1'b1;
    exp_err   = 1'b0;
  endtask

  task automatic model_edge(input logic [8:0] f, input logic r);
    logic        acc;
    logic        comp;
    logic [35:0] w;
    acc     = f[8] && (fifo.size() < 2);
    comp    = 1'b0;
    exp_err = 1'b0;
    if (r && fifo.size() > 0) void'(fifo.pop_front());
    if (acc) begin
      if (f[7]) begin
        if (part.size() > 0) exp_err = 1'b1;
        part.delete();
        part.push_back(f);
        comp = f[6];
      end else if (part.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        part.push_back(f);
        if (f[6]) begin
          comp = 1'b1;
        end else if (part.size() == 4) begin
          comp    = 1'b1;
          exp_err = 1'b1;
        end
      end
    end
    if (comp) begin
      w = '0;
      for (int i = 0; i < part.size(); i++)
        w[35-9*i -: 9] = part[i];
      part.delete();
      fifo.push_back(w);
    end
    exp_data  = (fifo.size() > 0) ? fifo[0] : '0;
    exp_ready = (fifo.size() < 2);
  endtask

  task automatic step(input logic [8:0] f, input logic r, input string tag);
    flit_in  = f;
    ready_in = r;
    model_edge(f, r);
    @(posedge clk);
    #1;
    chk({tag, ".data"}, data_out, exp_data);
    chk({tag, ".rdy"}, 36'(ready_out), 36'(exp_ready));
    chk({tag, ".err"}, 36'(error_out), 36'(exp_err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".data"}, data_out, 36'h0);
    chk({tag, ".rdy"}, 36'(ready_out), 36'h1);
    chk({tag, ".err"}, 36'(error_out), 36'h0);
  endtask

  initial begin
    logic [63:0] sl;
    logic [8:0]  rf;
    rst_n    = 1'b0;
    flit_in  = '0;
    ready_in = 1'b0;
    model_clear();
    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(9'h0, 1'b0, "idle0");

    // Four-flit packet, consumer ready.
    step(mk(1, 0, 0, 5'h1), 1'b1, "p4.h");
    step(mk(0, 0, 0, 5'h2), 1'b1, "p4.b1");
    step(mk(0, 0, 0, 5'h3), 1'b1, "p4.b2");
    step(mk(0, 1, 0, 5'h4), 1'b1, "p4.t");
    chk("p4.word", data_out, {9'h181, 9'h102, 9'h103, 9'h144});
    sl = get_slot(256'(data_out), 36, 9, 3);
    chk("p4.slot3", 36'(sl[8:0]), 36'h144);
    step(9'h0, 1'b1, "p4.consume");

    // Single-flit packet.
    step(mk(1, 1, 0, 5'h5), 1'b0, "p1");
    chk("p1.word", data_out, {9'h1C5, 27'h0});
    step(9'h0, 1'b1, "p1.consume");

    // Three 2-flit packets with the consumer stalled.
    step(mk(1, 0, 1, 5'h11), 1'b0, "bb1.h");
    step(mk(0, 1, 1, 5'h12), 1'b0, "bb1.t");
    step(mk(1, 0, 0, 5'h13), 1'b0, "bb2.h");
    step(mk(0, 1, 0, 5'h14), 1'b0, "bb2.t");
    chk("bb.hold", 36'(ready_out), 36'h0);
    step(mk(1, 0, 0, 5'h15), 1'b0, "bb.stall");
    step(9'h0, 1'b1, "bb.rel1");
    chk("bb.second", data_out,
        {mk(1, 0, 0, 5'h13), mk(0, 1, 0, 5'h14), 18'h0});
    step(mk(1, 0, 1, 5'h15), 1'b0, "bb3.h");
    step(mk(0, 1, 1, 5'h16), 1'b0, "bb3.t");
    step(9'h0, 1'b1, "bb.rel2");
    step(9'h0, 1'b1, "bb.rel3");
    chk("bb.empty", data_out, 36'h0);

    // Body flit with no packet open.
    step(mk(0, 0, 0, 5'h7), 1'b1, "orph");
    chk("orph.err", 36'(error_out), 36'h1);
    step(9'h0, 1'b1, "orph.after");

    // Head interrupting a partial packet.
    step(mk(1, 0, 0, 5'h8), 1'b1, "int.h1");
    step(mk(0, 0, 0, 5'h9), 1'b1, "int.b");
    step(mk(1, 0, 1, 5'hA), 1'b1, "int.h2");
    chk("int.err", 36'(error_out), 36'h1);
    step(mk(0, 1, 1, 5'hB), 1'b1, "int.t");
    chk("int.word", data_out,
        {mk(1, 0, 1, 5'hA), mk(0, 1, 1, 5'hB), 18'h0});
    step(9'h0, 1'b1, "int.consume");

    // Four flits without a tail.
    step(mk(1, 0, 0, 5'h1), 1'b1, "nt.h");
    step(mk(0, 0, 0, 5'h2), 1'b1, "nt.b1");
    step(mk(0, 0, 0, 5'h3), 1'b1, "nt.b2");
    step(mk(0, 0, 0, 5'h4), 1'b1, "nt.b3");
    step(9'h0, 1'b1, "nt.consume");

    // Reset in the middle of a packet.
    step(mk(1, 0, 0, 5'h1C), 1'b0, "rst.h");
    step(mk(0, 0, 0, 5'h1D), 1'b0, "rst.b");
    rst_n = 1'b0;
    #3;
    chk_reset_vals("rst.mid");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(1, 0, 0, 5'h1E), 1'b1, "rst.nh");
    step(mk(0, 1, 0, 5'h1F), 1'b1, "rst.nt");
    chk("rst.word", data_out,
        {mk(1, 0, 0, 5'h1E), mk(0, 1, 0, 5'h1F), 18'h0});
    step(9'h0, 1'b1, "rst.consume");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rf    = 9'($urandom);
      rf[8] = ($urandom_range(0, 9) < 7);
      rf[7] = ($urandom_range(0, 9) < 3);
      rf[6] = ($urandom_range(0, 9) < 4);
      step(rf, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
